// File: rtl/screen_manager.sv
// screen_manager: game-phase sequencer (START / GAME / END) for the display path.
// Phase changes are applied only on startOfFrame so the picture never tears.
// Ports:
//   clk, resetN          pixel clock, asynchronous active-low reset
//   startOfFrame         one-cycle pulse on pixel (0,0)
//   keyStart             raw start key (async, active-high)
//   gameOver             end-of-game indication from game logic
//   RGB_screen_*         candidate pixel colours
//   RGB_out              registered selected colour
//   screenState          current phase (0 START, 1 GAME, 2 END)
//   gameStart            one-cycle pulse on entry to GAME
//   gameActive           high while in GAME
module screen_manager #(
  parameter int unsigned END_HOLD_FRAMES = 120,
  parameter logic [7:0]  COLOR_IDLE      = 8'h00
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       keyStart,
  input  logic       gameOver,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_game,
  input  logic [7:0] RGB_screen_end,
  output logic [7:0] RGB_out,
  output logic [1:0] screenState,
  output logic       gameStart,
  output logic       gameActive
);

  localparam int unsigned HOLD_W = (END_HOLD_FRAMES == 0) ? 1 : $clog2(END_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(END_HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_END   = 2'd2
  } state_t;

  state_t             state, state_next;
  logic               pending, pending_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic               start_next;
  logic               trigger, apply;

  logic key_meta, key_sync, key_prev, key_pressed;

  // All key flops reset high: a key held through reset must be released first.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      key_meta <= keyStart;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign key_pressed = key_sync & ~key_prev;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_START;
      pending   <= 1'b0;
      hold_cnt  <= '0;
      gameStart <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      hold_cnt  <= hold_next;
      gameStart <= start_next;
    end
  end

  // Next-state logic
  always_comb begin
    trigger = 1'b0;
    case (state)
      ST_START: trigger = key_pressed;
      ST_GAME:  trigger = gameOver;
      ST_END:   trigger = key_pressed && (hold_cnt == '0);
      default:  trigger = 1'b0;
    endcase

    // A trigger in the frame-start cycle itself is applied at once.
    apply = startOfFrame && (pending || trigger);

    state_next   = state;
    pending_next = pending;
    hold_next    = hold_cnt;
    start_next   = 1'b0;

    if (apply) begin
      pending_next = 1'b0;
    end else if (trigger) begin
      pending_next = 1'b1;
    end

    if ((state == ST_END) && startOfFrame && (hold_cnt != '0)) begin
      hold_next = hold_cnt - HOLD_W'(1);
    end

    case (state)
      ST_START: begin
        if (apply) begin
          state_next = ST_GAME;
          start_next = 1'b1;
        end
      end
      ST_GAME: begin
        if (apply) begin
          state_next = ST_END;
          hold_next  = HOLD_LOAD;
        end
      end
      ST_END: begin
        if (apply) begin
          state_next = ST_START;
        end
      end
      default: begin
        state_next   = ST_START;
        pending_next = 1'b0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    screenState = state;
    gameActive  = (state == ST_GAME);
  end

  // Colour select uses the pre-update state, giving one cycle of RGB latency.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGB_out <= COLOR_IDLE;
    end else begin
      case (state)
        ST_START: RGB_out <= RGB_screen_start;
        ST_GAME:  RGB_out <= RGB_screen_game;
        ST_END:   RGB_out <= RGB_screen_end;
        default:  RGB_out <= COLOR_IDLE;
      endcase
    end
  end

endmodule
